booth_mult_param: RTL

Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 32-bit multiplier in the execute stage. Adds width parameter, per-operation signed/unsigned mode, explicit busy/done handshake and back-to-back issue. Sits beside the ALU; control FSM starts it and stalls on multBusy until multStop.

---
 rtl/booth_mult_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/booth_mult_param.sv
// ============================================================================
// Module   : booth_mult_param
// Brief    : Parametrised sequential radix-2 Booth multiplier, signed/unsigned
//            per operation, busy/done handshake, back-to-back issue.
//            Optional macro MULT_ZERO_SKIP_EN: zero operand finishes in 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             isSigned,
    input  logic             multControl,
    output logic             multBusy,
    output logic             multStop,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_EXT = WIDTH + 1;
    localparam int c_ACC = 2 * WIDTH + 3;
    localparam int c_CW  = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [c_EXT-1:0]  r_m, w_m_next;
    logic [c_ACC-1:0]  r_acc, w_acc_next;
    logic [c_CW-1:0]   r_cnt, w_cnt_next;
    logic [WIDTH-1:0]  r_hi, r_lo, w_hi_next, w_lo_next;

    logic [c_EXT-1:0]  w_a_ext, w_b_ext, w_upper, w_sum;
    logic [c_ACC-1:0]  w_shifted;

    // The extra top bit keeps most-negative and all-ones operands exact.
    assign w_a_ext = {isSigned & a[WIDTH-1], a};
    assign w_b_ext = {isSigned & b[WIDTH-1], b};
    assign w_upper = r_acc[c_ACC-1:c_EXT+1];

    always_comb begin
        w_sum = w_upper;
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper + r_m;
            2'b10:   w_sum = w_upper - r_m;
            default: w_sum = w_upper;
        endcase
        w_shifted = {w_sum[c_EXT-1], w_sum, r_acc[c_EXT:1]};
    end

    always_comb begin
        w_state_next = r_state;
        w_m_next     = r_m;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        case (r_state)
            RUN: begin
                w_acc_next = w_shifted;
                w_cnt_next = r_cnt - c_CW'(1);
                if (r_cnt == c_CW'(1)) begin
                    w_state_next = DONE;
                    w_hi_next    = w_shifted[2*WIDTH:WIDTH+1];
                    w_lo_next    = w_shifted[WIDTH:1];
                end
            end
            IDLE, DONE: begin
                w_state_next = IDLE;
                if (multControl) begin
                    w_m_next     = w_a_ext;
                    w_acc_next   = {{c_EXT{1'b0}}, w_b_ext, 1'b0};
                    w_cnt_next   = c_CW'(WIDTH + 1);
                    w_state_next = RUN;
`ifdef MULT_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        w_state_next = DONE;
                        w_hi_next    = '0;
                        w_lo_next    = '0;
                    end
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_m     <= w_m_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    assign multBusy = (r_state == RUN);
    assign multStop = (r_state == DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire
